// File: rtl/mul_accumulator.sv
// Sums len_in products from the upstream multiplier into a wide accumulator; result valid the cycle after the final transfer.
// p_ready_out is high only in ACCUM (one product per cycle); the result is held in HOLD until acc_ready_in.
module mul_accumulator #(
  parameter int MUL_WIDTH = 8,
  parameter int ACC_WIDTH = 2*MUL_WIDTH+8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [CNT_WIDTH-1:0]   len_in,
  input  logic [2*MUL_WIDTH-1:0] p_in,
  input  logic                   p_valid_in,
  output logic                   p_ready_out,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid_out,
  input  logic                   acc_ready_in,
  output logic                   busy_out,
  output logic                   ovf_out
);

  localparam int PW = 2*MUL_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [ACC_WIDTH:0]   sum_ext;

  // One extra bit catches the carry out of the accumulator for the sticky overflow flag.
  always_comb begin
    sum_ext = {1'b0, acc_out} + {{(ACC_WIDTH+1-PW){1'b0}}, p_in};
    cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      acc_out       <= '0;
      acc_valid_out <= 1'b0;
      p_ready_out   <= 1'b0;
      busy_out      <= 1'b0;
      ovf_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            acc_out  <= '0;
            ovf_out  <= 1'b0;
            cnt      <= '0;
            busy_out <= 1'b1;
            if (len_in != '0) begin
              len_q       <= len_in;
              p_ready_out <= 1'b1;
              state       <= ACCUM;
            end else begin
              acc_valid_out <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (p_valid_in) begin
            acc_out <= sum_ext[ACC_WIDTH-1:0];
            ovf_out <= ovf_out | sum_ext[ACC_WIDTH];
            cnt     <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              p_ready_out   <= 1'b0;
              acc_valid_out <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        HOLD: begin
          // acc_out and ovf_out are left alone so the last result stays readable in IDLE.
          if (acc_ready_in) begin
            acc_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          acc_valid_out <= 1'b0;
          p_ready_out   <= 1'b0;
          busy_out      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: directed scenarios plus randomized runs against a plain-arithmetic sum model.
module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] p;
  logic        p_valid;
  logic        p_ready;
  logic [23:0] acc;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;
  logic        ovf;

  // Narrow-accumulator instance used to exercise overflow.
  logic        start_b;
  logic [7:0]  len_b;
  logic [15:0] p_b;
  logic        p_valid_b;
  logic        p_ready_b;
  logic [16:0] acc_b;
  logic        acc_valid_b;
  logic        acc_ready_b;
  logic        busy_b;
  logic        ovf_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_accumulator dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .len_in(len),
    .p_in(p), .p_valid_in(p_valid), .p_ready_out(p_ready),
    .acc_out(acc), .acc_valid_out(acc_valid), .acc_ready_in(acc_ready),
    .busy_out(busy), .ovf_out(ovf)
  );

  mul_accumulator #(.MUL_WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .len_in(len_b),
    .p_in(p_b), .p_valid_in(p_valid_b), .p_ready_out(p_ready_b),
    .acc_out(acc_b), .acc_valid_out(acc_valid_b), .acc_ready_in(acc_ready_b),
    .busy_out(busy_b), .ovf_out(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] val, input int gaps);
    repeat (gaps) begin
      p_valid = 1'b0;
      p       = 16'hdead;
      tick();
    end
    p_valid = 1'b1;
    p       = val;
    tick();
    p_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (acc !== 24'd0)     begin errors++; $display("FAIL reset_acc got=%0d exp=0", acc); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%b exp=0", acc_valid); end
    checks++; if (p_ready !== 1'b0)  begin errors++; $display("FAIL reset_p_ready got=%b exp=0", p_ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (acc_valid_b !== 1'b0 || busy_b !== 1'b0 || p_ready_b !== 1'b0)
      begin errors++; $display("FAIL reset_b got=%b%b%b exp=000", acc_valid_b, busy_b, p_ready_b); end
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    do_start(8'd3);
    checks++; if (busy !== 1'b1 || p_ready !== 1'b1)
      begin errors++; $display("FAIL basic_accum_entry got busy=%b rdy=%b exp=1,1", busy, p_ready); end
    send(16'd2000, 0);
    send(16'd2000, 0);
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", acc_valid); end
    send(16'd2000, 0);
    checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", acc_valid); end
    checks++; if (acc !== 24'd6000)   begin errors++; $display("FAIL basic_acc got=%0d exp=6000", acc); end
    checks++; if (ovf !== 1'b0 || p_ready !== 1'b0)
      begin errors++; $display("FAIL basic_flags got ovf=%b rdy=%b exp=0,0", ovf, p_ready); end
    tick();
    checks++; if (acc_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_release got valid=%b busy=%b exp=0,0", acc_valid, busy); end
  endtask

  task automatic test_bubbles();
    acc_ready = 1'b0;
    do_start(8'd4);
    for (int i = 1; i <= 4; i++) send(i[15:0], 2);
    // Stray products and starts while holding must not disturb the result.
    p_valid = 1'b1;
    p       = 16'd99;
    start   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (acc !== 24'd10 || acc_valid !== 1'b1 || p_ready !== 1'b0)
        begin errors++; $display("FAIL bubble_hold[%0d] got acc=%0d v=%b rdy=%b exp=10,1,0", c, acc, acc_valid, p_ready); end
      tick();
    end
    p_valid   = 1'b0;
    acc_ready = 1'b1;
    tick();
    start     = 1'b0;
    checks++; if (acc_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bubble_release got v=%b busy=%b exp=0,0", acc_valid, busy); end
    checks++; if (acc !== 24'd10) begin errors++; $display("FAIL bubble_acc_kept got=%0d exp=10", acc); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_exit_start got busy=%b exp=0", busy); end
  endtask

  task automatic test_zero_len();
    acc_ready = 1'b0;
    p_valid   = 1'b1;
    p         = 16'd5;
    do_start(8'd0);
    checks++; if (acc_valid !== 1'b1 || acc !== 24'd0)
      begin errors++; $display("FAIL zero_result got v=%b acc=%0d exp=1,0", acc_valid, acc); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL zero_p_ready got=%b exp=0", p_ready); end
    tick();
    checks++; if (acc !== 24'd0) begin errors++; $display("FAIL zero_no_accept got=%0d exp=0", acc); end
    p_valid   = 1'b0;
    acc_ready = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    acc_ready_b = 1'b1;
    start_b = 1'b1; len_b = 8'd3; tick(); start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_valid_b = 1'b1; p_b = 16'd65025; tick();
    end
    p_valid_b = 1'b0;
    checks++; if (acc_b !== 17'd64003 || acc_valid_b !== 1'b1)
      begin errors++; $display("FAIL ovf_acc got=%0d v=%b exp=64003,1", acc_b, acc_valid_b); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf_b); end
    tick();
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle got=%b exp=1", ovf_b); end
    start_b = 1'b1; len_b = 8'd1; tick(); start_b = 1'b0;
    checks++; if (ovf_b !== 1'b0 || acc_b !== 17'd0)
      begin errors++; $display("FAIL ovf_clear got ovf=%b acc=%0d exp=0,0", ovf_b, acc_b); end
    p_valid_b = 1'b1; p_b = 16'd1; tick(); p_valid_b = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    acc_ready = 1'b1;
    do_start(8'd5);
    send(16'd11, 0);
    start = 1'b1; len = 8'd1;
    send(16'd22, 0);
    start = 1'b0;
    checks++; if (acc !== 24'd33 || busy !== 1'b1 || p_ready !== 1'b1)
      begin errors++; $display("FAIL stray_start got acc=%0d busy=%b rdy=%b exp=33,1,1", acc, busy, p_ready); end
    rst_n = 1'b0;
    tick();
    checks++; if (acc !== 24'd0 || acc_valid !== 1'b0 || busy !== 1'b0 || p_ready !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL midrun_reset got acc=%0d v=%b b=%b r=%b o=%b exp=all 0", acc, acc_valid, busy, p_ready, ovf); end
    rst_n = 1'b1;
    tick();
    do_start(8'd1);
    send(16'd7, 0);
    checks++; if (acc !== 24'd7 || acc_valid !== 1'b1)
      begin errors++; $display("FAIL after_reset_run got acc=%0d v=%b exp=7,1", acc, acc_valid); end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int unsigned n;
      longint unsigned total;
      logic [15:0] val;
      logic exp_ovf;
      n     = $urandom_range(20, 1);
      total = 0;
      acc_ready = 1'b0;
      do_start(n[7:0]);
      for (int k = 0; k < int'(n); k++) begin
        checks++; if (acc_valid !== 1'b0)
          begin errors++; $display("FAIL rand_early_valid run=%0d term=%0d got=%b exp=0", r, k, acc_valid); end
        val   = 16'($urandom);
        total = total + val;
        send(val, (r % 3 == 0) ? 0 : $urandom_range(2, 0));
      end
      exp_ovf = (total >= 64'd16777216);
      checks++; if (acc_valid !== 1'b1 || acc !== total[23:0] || ovf !== exp_ovf)
        begin errors++; $display("FAIL rand_run=%0d got acc=%0d v=%b o=%b exp=%0d,1,%b", r, acc, acc_valid, ovf, total[23:0], exp_ovf); end
      repeat ($urandom_range(3, 0)) tick();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      checks++; if (acc_valid !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL rand_release run=%0d got v=%b busy=%b exp=0,0", r, acc_valid, busy); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; p = '0; p_valid = 1'b0; acc_ready = 1'b0;
    start_b = 1'b0; len_b = '0; p_b = '0; p_valid_b = 1'b0; acc_ready_b = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_overflow();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
Sequential stage directly downstream of array_multiplier. It consumes the 2*MUL_WIDTH-bit products on m_out one per handshake and sums a programmed number of terms into a wide accumulator (dot-product / MAC reduction). It presents the final sum on a valid/ready result port and holds it until the consumer accepts it.

Parameters:
MUL_WIDTH, 8, operand width of the upstream multiplier; the product is 2*MUL_WIDTH bits.
ACC_WIDTH, 2*MUL_WIDTH+8, accumulator and result width. Must be >= 2*MUL_WIDTH.
CNT_WIDTH, 8, width of the term-count field. Maximum terms per run is 2^CNT_WIDTH-1.

Ports:
clk_in  input  1  rising-edge clock. This is the only clock.
rst_n_in  input  1  synchronous reset, active-low.
start_in  input  1  single-cycle run request. Sampled only in IDLE.
len_in  input  CNT_WIDTH  number of products to sum. Latched when start is accepted.
p_in  input  2*MUL_WIDTH  product from array_multiplier m_out.
p_valid_in  input  1  p_in is valid.
p_ready_out  output  1  block accepts p_in this cycle.
acc_out  output  ACC_WIDTH  accumulated sum.
acc_valid_out  output  1  acc_out holds a completed result.
acc_ready_in  input  1  consumer accepts the result.
busy_out  output  1  high whenever the block is not in IDLE.
ovf_out  output  1  sticky flag: the sum exceeded ACC_WIDTH during the run.

Behaviour:
- Reset (rst_n_in low at a clock edge): state returns to IDLE. acc_out, acc_valid_out, p_ready_out, busy_out, ovf_out, the term counter and the latched length all clear to 0. Reset takes priority over every other event; a reset mid-run aborts the run with no result.
- State machine: IDLE, ACCUM, HOLD. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - start_in=1 with len_in!=0: latch len_in, clear acc, counter and ovf, then go to ACCUM.
  - start_in=1 with len_in=0: clear acc and ovf, then go to HOLD (empty sum = 0).
  - start_in=0: stay in IDLE.
- ACCUM:
  - p_ready_out=1, busy_out=1.
  - A transfer occurs when p_valid_in && p_ready_out at a clock edge. On a transfer: acc <= acc + zero-extended p_in (modulo 2^ACC_WIDTH), count <= count+1, and ovf is set if the addition carries out of bit ACC_WIDTH-1.
  - On the transfer that makes count equal to the latched length, go to HOLD.
  - p_valid_in=0 inserts a bubble: nothing changes.
- HOLD:
  - acc_valid_out=1, p_ready_out=0. acc_out and ovf_out are stable.
  - When acc_ready_in=1 at a clock edge, go to IDLE. acc_valid_out drops the next cycle. acc_out and ovf_out keep their last values until the next start is accepted.
- Latency: acc_valid_out rises on the first cycle after the clock edge of the final product transfer. Back-to-back products are accepted at one per cycle with no stalls.
- start_in is ignored in ACCUM and HOLD. start_in in the same cycle that HOLD exits is also ignored; a new start is accepted from IDLE only, so there is at least one IDLE cycle between runs.
- acc_ready_in is ignored outside HOLD. p_valid_in is ignored outside ACCUM.
- Widths: the counter is CNT_WIDTH bits and never wraps, because the run ends at len <= 2^CNT_WIDTH-1. With the default parameters, a full-scale run (255 x 65025) fits without overflow.
- ovf_out is sticky for the whole run and clears only on an accepted start or a reset. It never asserts with the default parameters.

Test Plan:
- Reset then idle: rst_n_in low for 2 cycles, then release -> all outputs 0, p_ready_out=0, state IDLE.
- Basic run: start with len=3; products 2000, 2000, 2000 (40*50) on consecutive cycles -> acc_valid_out=1 on the cycle after the 3rd transfer, acc_out=6000, ovf_out=0; with acc_ready_in=1 the block returns to IDLE.
- Bubbles and backpressure: len=4; products 1, 2, 3, 4 with p_valid_in low for 2 cycles between terms; acc_ready_in held low for 5 cycles -> acc_out=10 stable for all 5 cycles, acc_valid_out high throughout, p_ready_out=0 in HOLD; the result is released on the first acc_ready_in=1.
- Zero length: start with len=0 -> no product is accepted (p_ready_out stays 0), acc_valid_out=1 the next cycle with acc_out=0.
- Overflow: ACC_WIDTH=17, MUL_WIDTH=8, len=3, products 65025 x3 -> acc_out=64003 (195075 mod 131072), ovf_out=1; the next start clears ovf_out.
- Reset mid-run and stray start: issue start_in during ACCUM (ignored, count continues); then assert rst_n_in low after 2 of 5 products -> next cycle everything is 0 and state is IDLE; the following run with len=1 and product 7 gives acc_out=7.
